// File: rtl/alu_mul_seq_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package alu_mul_seq_pkg;

  localparam int unsigned Width = 16;

  // ALU control bits in order {zx, nx, zy, ny, f, no}; this value selects x + y.
  localparam logic [5:0] AluAddCtrl = 6'b000010;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StDbl,
    StDone
  } state_e;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Operand/product handshake bundle between a producer/consumer and the multiplier.
interface alu_mul_seq_if;
  import alu_mul_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] product;
  logic             zr;
  logic             ng;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, zr, ng
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, zr, ng
  );

endinterface

// File: rtl/alu_mul_seq_alu.sv
// Combinational ALU with zero/negate controls on each operand, add/and select and
// output negate.
module alu_mul_seq_alu
  import alu_mul_seq_pkg::*;
(
  input  logic [Width-1:0] i_x,
  input  logic [Width-1:0] i_y,
  input  logic [5:0]       i_ctrl,
  output logic [Width-1:0] o_out
);

  logic [Width-1:0] w_x_z, w_x_n, w_y_z, w_y_n, w_f;

  assign w_x_z = i_ctrl[5] ? '0 : i_x;
  assign w_x_n = i_ctrl[4] ? ~w_x_z : w_x_z;
  assign w_y_z = i_ctrl[3] ? '0 : i_y;
  assign w_y_n = i_ctrl[2] ? ~w_y_z : w_y_z;
  assign w_f   = i_ctrl[1] ? (w_x_n + w_y_n) : (w_x_n & w_y_n);
  assign o_out = i_ctrl[0] ? ~w_f : w_f;

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential 16x16 multiplier (low 16 bits) built on a single shared ALU used as an
// adder: ADD conditionally accumulates the multiplicand, DBL doubles it and shifts
// the multiplier right; stops once no multiplier bits remain.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  alu_mul_seq_if.slave io_bus
);

  state_e           r_state, w_state_d;
  logic [Width-1:0] r_acc, w_acc_d;
  logic [Width-1:0] r_mcand, w_mcand_d;
  logic [Width-1:0] r_mplier, w_mplier_d;
  logic [Width-1:0] w_alu_x, w_alu_y, w_alu_out;
  logic [Width-1:0] w_mplier_shr;

  assign w_mplier_shr = r_mplier >> 1;

  // ALU operand select: DBL adds mcand to itself, otherwise acc + mcand.
  always_comb begin
    w_alu_x = r_acc;
    w_alu_y = r_mcand;
    if (r_state == StDbl) begin
      w_alu_x = r_mcand;
    end
  end

  alu_mul_seq_alu u_alu (
    .i_x    (w_alu_x),
    .i_y    (w_alu_y),
    .i_ctrl (AluAddCtrl),
    .o_out  (w_alu_out)
  );

  // Next-state and datapath updates for the handshake/shift-add sequence.
  always_comb begin
    w_state_d  = r_state;
    w_acc_d    = r_acc;
    w_mcand_d  = r_mcand;
    w_mplier_d = r_mplier;
    unique case (r_state)
      StIdle: begin
        if (io_bus.in_valid) begin
          w_acc_d    = '0;
          w_mcand_d  = io_bus.a;
          w_mplier_d = io_bus.b;
          w_state_d  = (io_bus.b == '0) ? StDone : StAdd;
        end
      end
      StAdd: begin
        if (r_mplier[0]) begin
          w_acc_d = w_alu_out;
        end
        w_state_d = StDbl;
      end
      StDbl: begin
        w_mcand_d  = w_alu_out;
        w_mplier_d = w_mplier_shr;
        w_state_d  = (w_mplier_shr == '0) ? StDone : StAdd;
      end
      StDone: begin
        if (io_bus.out_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset wins over accept and handoff.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      r_state  <= w_state_d;
      r_acc    <= w_acc_d;
      r_mcand  <= w_mcand_d;
      r_mplier <= w_mplier_d;
    end
  end

  assign io_bus.in_ready  = (r_state == StIdle);
  assign io_bus.out_valid = (r_state == StDone);
  assign io_bus.product   = r_acc;
  assign io_bus.zr        = (r_acc == '0);
  assign io_bus.ng        = r_acc[Width-1];

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: directed operand pairs with literal expectations plus a
// cycle-level transaction model checked against the outputs every cycle.
module tb_alu_mul_seq;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_mul_seq_if bus ();

  alu_mul_seq dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycles from accept edge (counted as 1) until out_valid is seen.
  function automatic int model_latency(input logic [15:0] bv);
    int k;
    k = -1;
    for (int i = 0; i < 16; i++) if (bv[i]) k = i;
    return (k < 0) ? 1 : 2 * (k + 1) + 1;
  endfunction

  // Transaction model: 0 idle, 1 busy, 2 product waiting.
  int          m_phase = 0;
  int          m_left  = 0;
  logic [15:0] m_prod  = '0;
  bit          m_live  = 1'b0;

  always @(posedge clk) begin
    logic [31:0] full;
    if (!rst_n) begin
      m_phase = 0;
      m_prod  = '0;
      m_live  = 1'b1;
    end else begin
      case (m_phase)
        0: if (bus.in_valid) begin
          full    = bus.a * bus.b;
          m_prod  = full[15:0];
          m_left  = model_latency(bus.b) - 1;
          m_phase = (m_left == 0) ? 2 : 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (bus.out_ready) m_phase = 0;
      endcase
    end
  end

  // Every-cycle comparison against the model; product only meaningful when not busy.
  always @(negedge clk) begin
    if (m_live) begin
      chk("model in_ready", {31'd0, bus.in_ready}, {31'd0, m_phase == 0});
      chk("model out_valid", {31'd0, bus.out_valid}, {31'd0, m_phase == 2});
      if (m_phase != 1) begin
        chk("model product", {16'd0, bus.product}, {16'd0, m_prod});
        chk("model zr", {31'd0, bus.zr}, {31'd0, m_prod == 16'd0});
        chk("model ng", {31'd0, bus.ng}, {31'd0, m_prod[15]});
      end
    end
  end

  // Starts at posedge+1 in IDLE; returns at posedge+1 in IDLE after handoff.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv,
                        input logic [15:0] exp_p, input int exp_lat,
                        input bit exp_zr, input bit exp_ng, input int hold);
    int cyc;
    bit seen;
    bus.out_ready = (hold == 0);
    bus.a         = ta;
    bus.b         = tbv;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    cyc  = 1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    chk("out_valid seen", {31'd0, seen}, 32'd1);
    chk("latency", cyc, exp_lat);
    chk("product", {16'd0, bus.product}, {16'd0, exp_p});
    chk("zr", {31'd0, bus.zr}, {31'd0, exp_zr});
    chk("ng", {31'd0, bus.ng}, {31'd0, exp_ng});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.a        = 16'h1111;
      bus.b        = 16'h0003;
      @(negedge clk);
      chk("hold out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("hold product", {16'd0, bus.product}, {16'd0, exp_p});
    end
    if (hold > 0) begin
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("idle after handoff", {31'd0, bus.in_ready}, 32'd1);
    chk("no out_valid after handoff", {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset product", {16'd0, bus.product}, 32'd0);
    chk("reset zr", {31'd0, bus.zr}, 32'd1);
    chk("reset ng", {31'd0, bus.ng}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_op(16'd3,    16'd5,    16'd15,   7,  1'b0, 1'b0, 0);
    run_op(16'd1234, 16'd0,    16'd0,    1,  1'b1, 1'b0, 0);
    run_op(16'hFFFD, 16'd7,    16'hFFEB, 7,  1'b0, 1'b1, 0);
    run_op(16'd2,    16'hFFFF, 16'hFFFE, 33, 1'b0, 1'b1, 0);
    run_op(16'h0100, 16'h0100, 16'h0000, 19, 1'b1, 1'b0, 0);
    run_op(16'd6,    16'd7,    16'd42,   7,  1'b0, 1'b0, 5);
    run_op(16'd5,    16'd3,    16'd15,   5,  1'b0, 1'b0, 0);

    // Abort during DBL: accept, one edge into DBL, then a single reset cycle.
    bus.out_ready = 1'b1;
    bus.a         = 16'd9;
    bus.b         = 16'h8000;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort product", {16'd0, bus.product}, 32'd0);
    @(posedge clk);
    #1;
    run_op(16'd4, 16'd4, 16'd16, 7, 1'b0, 1'b0, 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
